// File: rtl/gate_arb_pkg.sv
// Shared constants for the round-robin gate arbiter.
// Opcode values, FSM state encoding and the statistics counter width.
package gate_arb_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int OPCNT_W = 16;

endpackage

// File: rtl/gate_alu.sv
// Combinational bitwise gate unit shared by all requesters.
// Applies AND/OR/XOR/NOR across WIDTH bits, no carry or extension.
module gate_alu
    import gate_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result
);

    // Select the gate function from the opcode
    always_comb begin
        result = '0;
        unique case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/gate_rr_arbiter.sv
// Round-robin front-end sharing one gate_alu among NUM_REQ requesters.
// Optional macro GATE_ARB_STATS_EN adds a saturating handshake counter (op_count).
module gate_rr_arbiter
    import gate_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   a_in,
    input  logic [NUM_REQ*WIDTH-1:0]   b_in,
    input  logic [NUM_REQ*2-1:0]       op_in,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       out_valid,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready
`ifdef GATE_ARB_STATS_EN
    ,
    output logic [OPCNT_W-1:0]         op_count
`endif
);

    localparam int IDW = $clog2(NUM_REQ);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_ptr_nxt;
    logic               w_found;
    logic               w_cap;
    logic               w_hs;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [1:0]         w_op;
    logic [WIDTH-1:0]   w_res;
    logic [NUM_REQ-1:0] w_onehot;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_valid;
    logic [IDW-1:0]     r_id;
    logic [WIDTH-1:0]   r_data;

    // First active request scanning upward from ptr with wrap-around
    always_comb begin
        int             j;
        logic [IDW-1:0] v_i;
        j       = 0;
        v_i     = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            v_i = IDW'(j);
            if (!w_found && req[v_i]) begin
                w_found = 1'b1;
                w_win   = v_i;
            end
        end
    end

    assign w_a       = a_in[int'(w_win)*WIDTH +: WIDTH];
    assign w_b       = b_in[int'(w_win)*WIDTH +: WIDTH];
    assign w_op      = op_in[int'(w_win)*2 +: 2];
    assign w_onehot  = NUM_REQ'(1) << w_win;
    assign w_ptr_nxt = (w_win == IDW'(NUM_REQ-1)) ? '0 : w_win + IDW'(1);

    gate_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (w_a),
        .b      (w_b),
        .op     (w_op),
        .result (w_res)
    );

    // Next-state: capture from IDLE, release HOLD on handshake
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_hs        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_cap       = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_valid && out_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture winner result, pulse grant, advance pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_data  <= '0;
        end else begin
            r_gnt <= '0;
            if (w_cap) begin
                r_gnt   <= w_onehot;
                r_valid <= 1'b1;
                r_id    <= w_win;
                r_data  <= w_res;
                r_ptr   <= w_ptr_nxt;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef GATE_ARB_STATS_EN
    logic [OPCNT_W-1:0] r_cnt;

    // Saturating count of accepted results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_hs && (r_cnt != {OPCNT_W{1'b1}})) begin
            r_cnt <= r_cnt + OPCNT_W'(1);
        end
    end

    assign op_count = r_cnt;
`endif

    assign gnt       = r_gnt;
    assign out_valid = r_valid;
    assign out_id    = r_id;
    assign out_data  = r_data;

endmodule
